// File: rtl/dac_multichannel_output.sv
// NUM_CH-channel sample sequencer driving an addressed SPI DAC, one frame per channel.
// Define DAC_SAT_EN to clamp scaled samples to the DAC range instead of truncating them.
module dac_multichannel_output #(
    parameter int                  NUM_CH        = 2,
    parameter int                  SAMPLE_W      = 32,
    parameter int                  DAC_BITS      = 16,
    parameter int                  SHIFT         = 2,
    parameter logic [SAMPLE_W-1:0] SAMPLE_OFFSET = SAMPLE_W'(32'h20500),
    parameter logic [3:0]          CMD_PREFIX    = 4'b0011,
    parameter int                  CLK_DIV       = 2,
    parameter int                  CS_GAP        = 2
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Start,
    input  logic [NUM_CH*SAMPLE_W-1:0] i_Samples,
    output logic                       o_Busy,
    output logic                       o_Done,
    output logic                       o_Overrun,
    output logic                       o_SPI_CS,
    output logic                       o_SPI_Clock,
    output logic                       o_SPI_Data
);

    localparam int FRAME_W = 8 + DAC_BITS;
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int GAP_W   = $clog2(CS_GAP + 1);
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [3:0]       CH_LAST  = 4'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SAMPLE_W-1:0] r_samples [NUM_CH];
    logic [3:0]          r_ch_idx;
    logic [3:0]          w_ch_idx_next;
    logic [FRAME_W-1:0]  r_shift;
    logic [FRAME_W-1:0]  w_shift_next;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [DIV_W-1:0]    w_div_cnt_next;
    logic                r_sck_phase;
    logic                w_sck_phase_next;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [BIT_W-1:0]    w_bit_cnt_next;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [GAP_W-1:0]    w_gap_cnt_next;

    logic r_cs;
    logic r_sck;
    logic r_data;
    logic r_busy;
    logic r_done;
    logic r_overrun;
    logic w_cs_next;
    logic w_sck_next;
    logic w_data_next;
    logic w_busy_next;
    logic w_done_next;
    logic w_overrun_next;

    logic [SAMPLE_W-1:0]        w_sample;
    logic signed [SAMPLE_W:0]   w_sample_ext;
    logic signed [SAMPLE_W:0]   w_offset_ext;
    logic signed [SAMPLE_W:0]   w_sum;
    logic signed [SAMPLE_W:0]   w_scaled;
    logic [DAC_BITS-1:0]        w_data;
    logic [FRAME_W-1:0]         w_frame;
    logic                       w_shift_last;
    logic                       w_gap_last;

    // Select the latched sample of the channel currently being loaded.
    always_comb begin
        w_sample = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sample = (r_ch_idx == 4'(i)) ? r_samples[i] : w_sample;
        end
    end

    assign w_sample_ext = $signed({w_sample[SAMPLE_W-1], w_sample});
    assign w_offset_ext = $signed({SAMPLE_OFFSET[SAMPLE_W-1], SAMPLE_OFFSET});
    assign w_sum        = w_sample_ext + w_offset_ext;
    assign w_scaled     = w_sum >>> SHIFT;

`ifdef DAC_SAT_EN
    // Clamp the scaled sample into the unsigned DAC range.
    always_comb begin
        if (w_scaled[SAMPLE_W]) begin
            w_data = '0;
        end else if (|w_scaled[SAMPLE_W-1:DAC_BITS]) begin
            w_data = '1;
        end else begin
            w_data = w_scaled[DAC_BITS-1:0];
        end
    end
`else
    // Legacy path: the upper bits are dropped and the value wraps.
    logic w_unused_bits;
    assign w_unused_bits = ^w_scaled[SAMPLE_W:DAC_BITS];
    assign w_data        = w_scaled[DAC_BITS-1:0];
`endif

    assign w_frame      = {CMD_PREFIX, r_ch_idx + 4'd1, w_data};
    assign w_shift_last = r_sck_phase && (r_div_cnt == DIV_LAST) && (r_bit_cnt == BIT_LAST);
    assign w_gap_last   = (r_gap_cnt == GAP_LAST);

    // State register.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_Start) begin
                    w_state_next = S_LOAD;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_LOAD: w_state_next = S_SHIFT;
            S_SHIFT: begin
                if (w_shift_last) begin
                    w_state_next = S_GAP;
                end else begin
                    w_state_next = S_SHIFT;
                end
            end
            S_GAP: begin
                if (w_gap_last) begin
                    w_state_next = (r_ch_idx == CH_LAST) ? S_DONE : S_LOAD;
                end else begin
                    w_state_next = S_GAP;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath next values: channel index, shift register and SCK timing counters.
    always_comb begin
        w_ch_idx_next    = r_ch_idx;
        w_shift_next     = r_shift;
        w_div_cnt_next   = r_div_cnt;
        w_sck_phase_next = r_sck_phase;
        w_bit_cnt_next   = r_bit_cnt;
        w_gap_cnt_next   = r_gap_cnt;
        case (r_state)
            S_IDLE: w_ch_idx_next = 4'd0;
            S_LOAD: begin
                w_shift_next     = w_frame;
                w_div_cnt_next   = '0;
                w_sck_phase_next = 1'b0;
                w_bit_cnt_next   = '0;
            end
            S_SHIFT: begin
                w_gap_cnt_next = '0;
                if (r_div_cnt == DIV_LAST) begin
                    w_div_cnt_next   = '0;
                    w_sck_phase_next = ~r_sck_phase;
                    // A bit ends after its high half; the next bit appears as SCK falls.
                    if (r_sck_phase) begin
                        w_bit_cnt_next = r_bit_cnt + BIT_ONE;
                        w_shift_next   = r_shift << 1;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt;
                        w_shift_next   = r_shift;
                    end
                end else begin
                    w_div_cnt_next = r_div_cnt + DIV_ONE;
                end
            end
            S_GAP: begin
                w_gap_cnt_next = r_gap_cnt + GAP_ONE;
                if (w_gap_last) begin
                    w_ch_idx_next = r_ch_idx + 4'd1;
                end else begin
                    w_ch_idx_next = r_ch_idx;
                end
            end
            S_DONE:  w_ch_idx_next = 4'd0;
            default: w_ch_idx_next = 4'd0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_ch_idx    <= 4'd0;
            r_shift     <= '0;
            r_div_cnt   <= '0;
            r_sck_phase <= 1'b0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_ch_idx    <= w_ch_idx_next;
            r_shift     <= w_shift_next;
            r_div_cnt   <= w_div_cnt_next;
            r_sck_phase <= w_sck_phase_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_gap_cnt   <= w_gap_cnt_next;
        end
    end

    // Sample latch: only an accepted start may overwrite the sample set.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_samples[i] <= '0;
            end
        end else if ((r_state == S_IDLE) && i_Start) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_samples[i] <= i_Samples[i*SAMPLE_W +: SAMPLE_W];
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_samples[i] <= r_samples[i];
            end
        end
    end

    // Output decode from the next state so the pins line up with the state they belong to.
    always_comb begin
        w_cs_next   = 1'b1;
        w_sck_next  = 1'b0;
        w_data_next = 1'b0;
        if (w_state_next == S_SHIFT) begin
            w_cs_next   = 1'b0;
            w_sck_next  = w_sck_phase_next;
            w_data_next = w_shift_next[FRAME_W-1];
        end else begin
            w_cs_next   = 1'b1;
            w_sck_next  = 1'b0;
            w_data_next = 1'b0;
        end
        w_busy_next    = (w_state_next == S_LOAD) || (w_state_next == S_SHIFT) ||
                         (w_state_next == S_GAP);
        w_done_next    = (w_state_next == S_DONE);
        w_overrun_next = i_Start && (r_state != S_IDLE);
    end

    // Output registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_cs      <= 1'b1;
            r_sck     <= 1'b0;
            r_data    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cs      <= w_cs_next;
            r_sck     <= w_sck_next;
            r_data    <= w_data_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_overrun <= w_overrun_next;
        end
    end

    assign o_SPI_CS    = r_cs;
    assign o_SPI_Clock = r_sck;
    assign o_SPI_Data  = r_data;
    assign o_Busy      = r_busy;
    assign o_Done      = r_done;
    assign o_Overrun   = r_overrun;

endmodule

// File: tb/tb_dac_multichannel_output.sv
// Bench for dac_multichannel_output: default two-channel instance checked by an SPI
// frame monitor against a scoreboard queue, plus a four-channel fast-clock instance.
module tb_dac_multichannel_output;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         a_start;
    logic [63:0]  a_samples;
    logic         a_busy, a_done, a_ovr, a_cs, a_sck, a_data;
    logic         b_start;
    logic [127:0] b_samples;
    logic         b_busy, b_done, b_ovr, b_cs, b_sck, b_data;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q [$];
    bit mon_en    = 1'b0;
    bit mon_abort = 1'b0;

    dac_multichannel_output dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_Start(a_start), .i_Samples(a_samples),
        .o_Busy(a_busy), .o_Done(a_done), .o_Overrun(a_ovr),
        .o_SPI_CS(a_cs), .o_SPI_Clock(a_sck), .o_SPI_Data(a_data)
    );

    dac_multichannel_output #(.NUM_CH(4), .CLK_DIV(1), .CS_GAP(1)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_Start(b_start), .i_Samples(b_samples),
        .o_Busy(b_busy), .o_Done(b_done), .o_Overrun(b_ovr),
        .o_SPI_CS(b_cs), .o_SPI_Clock(b_sck), .o_SPI_Data(b_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference frame: offset add, arithmetic shift by 2, then clamp or wrap to 16 bits.
    function automatic logic [23:0] model(input logic [31:0] s, input logic [3:0] addr);
        logic signed [32:0] sum;
        logic signed [32:0] sc;
        logic [15:0] d;
        sum = $signed({s[31], s}) + $signed({1'b0, 32'h00020500});
        sc  = sum >>> 2;
`ifdef DAC_SAT_EN
        if (sc < 0) d = 16'h0000;
        else if (sc > 33'sd65535) d = 16'hFFFF;
        else d = sc[15:0];
`else
        d = sc[15:0];
`endif
        return {4'b0011, addr, d};
    endfunction

    // SPI monitor for the default instance: rebuild each frame and pop the scoreboard.
    initial begin
        logic prev_cs, prev_sck, fall_sck;
        logic [23:0] cap, exp;
        int bits, cs_low;
        prev_cs = 1'b1; prev_sck = 1'b0; fall_sck = 1'b0; cap = '0; bits = 0; cs_low = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!a_cs && prev_cs) fall_sck = a_sck;
                if (!a_cs) begin
                    cs_low++;
                    if (a_sck && !prev_sck) begin
                        cap = {cap[22:0], a_data};
                        bits++;
                    end
                end
                if (a_cs && !prev_cs) begin
                    if (mon_abort) begin
                        mon_abort = 1'b0;
                    end else if (exp_q.size() == 0) begin
                        fail_now("unexpected_frame");
                    end else begin
                        exp = exp_q.pop_front();
                        chk("frame", cap, exp);
                        chk("frame_bits", bits, 24);
                        chk("cs_low_cycles", cs_low, 96);
                        chk("sck_low_at_cs_fall", fall_sck, 1'b0);
                    end
                    cap = '0; bits = 0; cs_low = 0;
                end
                if (a_cs && a_sck) fail_now("sck_high_while_cs_high");
                prev_cs  = a_cs;
                prev_sck = a_sck;
            end
        end
    end

    // One start on the default instance; optional extra start at cycle ovr_at and
    // per-cycle sample scrambling after the latch.
    task automatic run_set(input logic [63:0] s, input logic [23:0] e0, input logic [23:0] e1,
                           input int ovr_at, input bit chg);
        int n;
        bit done_seen;
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        a_samples = s;
        a_start   = 1'b1;
        n = 0;
        done_seen = 1'b0;
        while (!done_seen && n < 400) begin
            @(negedge clk);
            n++;
            a_start = (n == ovr_at);
            if (chg) a_samples = {$urandom, $urandom};
            if (n == 1) chk("busy_after_start", a_busy, 1'b1);
            if (n == ovr_at + 1) chk("overrun_pulse", a_ovr, 1'b1);
            if (a_done) begin
                done_seen = 1'b1;
                chk("done_cycle", n, 199);
                chk("busy_at_done", a_busy, 1'b0);
            end
        end
        if (!done_seen) fail_now("done_timeout");
        @(negedge clk);
        n++;
        a_start = 1'b0;
        if (n == ovr_at + 1) chk("overrun_in_done", a_ovr, 1'b1);
        chk("idle_after_done", a_busy, 1'b0);
        chk("done_single_pulse", a_done, 1'b0);
    endtask

    task automatic run_b();
        int n, k;
        bit done_seen;
        logic [23:0] cap;
        logic pcs, psck;
        b_samples = '0;
        b_start = 1'b1;
        n = 0; k = 0; cap = '0; pcs = 1'b1; psck = 1'b0; done_seen = 1'b0;
        while (!done_seen && n < 400) begin
            @(negedge clk);
            n++;
            b_start = 1'b0;
            if (!b_cs && b_sck && !psck) cap = {cap[22:0], b_data};
            if (b_cs && !pcs) begin
                chk("b_frame", cap, {4'b0011, 4'(k + 1), 16'h8140});
                k++;
                cap = '0;
            end
            pcs  = b_cs;
            psck = b_sck;
            if (b_done) begin
                done_seen = 1'b1;
                chk("b_done_cycle", n, 201);
            end
        end
        if (!done_seen) fail_now("b_done_timeout");
        chk("b_frame_count", k, 4);
    endtask

    typedef struct {
        logic [63:0] samples;
        logic [23:0] exp0;
        logic [23:0] exp1;
    } vec_t;

    initial begin
        vec_t vecs[8];
        logic [63:0] s;
        int n;

        rst = 1'b1; a_start = 1'b0; a_samples = '0; b_start = 1'b0; b_samples = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cs", a_cs, 1'b1);
        chk("reset_sck", a_sck, 1'b0);
        chk("reset_data", a_data, 1'b0);
        chk("reset_busy", a_busy, 1'b0);
        chk("reset_done", a_done, 1'b0);
        chk("reset_overrun", a_ovr, 1'b0);
        mon_en = 1'b1;

        vecs[0] = '{64'h00000000_00000000, 24'h318140, 24'h328140};
`ifdef DAC_SAT_EN
        vecs[1] = '{64'hFFF00000_7FFFFFFF, 24'h31FFFF, 24'h320000};
        vecs[3] = '{64'h0001FB00_0001FAFC, 24'h31FFFF, 24'h32FFFF};
        vecs[4] = '{64'h12345678_FFFDFAFF, 24'h310000, 24'h32FFFF};
`else
        vecs[1] = '{64'hFFF00000_7FFFFFFF, 24'h31813F, 24'h328140};
        vecs[3] = '{64'h0001FB00_0001FAFC, 24'h31FFFF, 24'h320000};
        vecs[4] = '{64'h12345678_FFFDFAFF, 24'h31FFFF, 24'h3296DE};
`endif
        vecs[2] = '{64'h00000004_FFFDFB00, 24'h310000, 24'h328141};
        for (int i = 5; i < 8; i++) begin
            s = {$urandom, $urandom};
            vecs[i] = '{s, model(s[31:0], 4'd1), model(s[63:32], 4'd2)};
        end

        for (int i = 0; i < 8; i++) begin
            run_set(vecs[i].samples, vecs[i].exp0, vecs[i].exp1, -1, 1'b0);
        end

        // Start during the ch0 frame while the sample bus keeps changing.
        s = 64'h0BADF00D_12345678;
        run_set(s, model(s[31:0], 4'd1), model(s[63:32], 4'd2), 50, 1'b1);

        // Start coinciding with the done cycle is rejected.
        s = 64'h00000000_00000000;
        run_set(s, 24'h318140, 24'h328140, 199, 1'b0);

        // Reset in the middle of the ch0 frame, then a fresh start at cycle 45.
        a_samples = 64'h11111111_22222222;
        a_start = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            a_start = 1'b0;
        end
        mon_abort = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        n++;
        rst = 1'b0;
        chk("abort_cs", a_cs, 1'b1);
        chk("abort_sck", a_sck, 1'b0);
        chk("abort_data", a_data, 1'b0);
        chk("abort_busy", a_busy, 1'b0);
        while (n < 45) begin
            @(negedge clk);
            n++;
            chk("no_done_after_abort", a_done, 1'b0);
        end
        s = 64'h00ABCDEF_FFFF0000;
        run_set(s, model(s[31:0], 4'd1), model(s[63:32], 4'd2), -1, 1'b0);

        run_b();

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
